// File: rtl/line_stepper.sv
// rtl/line_stepper.sv - sequential Bresenham line rasteriser, one pixel per cycle with valid/ready output
// Walks from (x1,y1) to (x2,y2) over any octant; stalls under backpressure, supports abort.
module line_stepper #(
    parameter int COORD_W = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic               abort,
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last,
    output logic               done
);

    localparam int EW = COORD_W + 2;
    localparam int DW = COORD_W + 3;

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x_q, x_d, y_q, y_d, xe_q, xe_d, ye_q, ye_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                 done_q, done_d;

    logic signed [EW-1:0] x_diff, y_diff, dx_init, dy_init;
    logic signed [DW-1:0] e2, dx_ext, dy_ext;
    logic                 step_x, step_y, at_end, handshake;

    // Zero-extend by two bits so the difference and its magnitude are both representable.
    assign x_diff  = $signed({2'b00, x2}) - $signed({2'b00, x1});
    assign y_diff  = $signed({2'b00, y2}) - $signed({2'b00, y1});
    assign dx_init = x_diff[EW-1] ? -x_diff : x_diff;
    assign dy_init = y_diff[EW-1] ? y_diff : -y_diff;

    assign e2     = {err_q, 1'b0};
    assign dx_ext = {dx_q[EW-1], dx_q};
    assign dy_ext = {dy_q[EW-1], dy_q};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    assign at_end    = (x_q == xe_q) && (y_q == ye_q);
    assign handshake = (state_q == S_EMIT) && pix_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_EMIT;
            S_EMIT: begin
                if (abort)                     state_d = S_IDLE;
                else if (handshake && at_end)  state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_EMIT);
        pix_valid = (state_q == S_EMIT);
        last      = (state_q == S_EMIT) && at_end;
        done      = done_q;
        x_o       = x_q;
        y_o       = y_q;
    end

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        xe_d     = xe_q;
        ye_d     = ye_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        done_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (start) begin
                x_d      = x1;
                y_d      = y1;
                xe_d     = x2;
                ye_d     = y2;
                dx_d     = dx_init;
                dy_d     = dy_init;
                err_d    = dx_init + dy_init;
                sx_neg_d = x_diff[EW-1];
                sy_neg_d = y_diff[EW-1];
            end
        end else if (!abort && handshake) begin
            if (at_end) begin
                done_d = 1'b1;
            end else begin
                // Both axis steps use the same e2, so their error updates simply accumulate.
                if (step_x) x_d = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
                if (step_y) y_d = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
                err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q      <= '0;
            y_q      <= '0;
            xe_q     <= '0;
            ye_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xe_q     <= xe_d;
            ye_q     <= ye_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_line_stepper.sv
// tb/tb_line_stepper.sv - self-checking bench for line_stepper with an integer line model and scoreboard
module tb_line_stepper;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic         abort = 1'b0;
    logic         busy, pix_valid, last, done;
    logic         pix_ready = 1'b1;
    logic [W-1:0] x_o, y_o;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_x[$], exp_y[$], log_x[$], log_y[$];
    int pv_prev = 0, pr_prev = 0, ab_prev = 0, px_prev = 0, py_prev = 0;

    line_stepper #(.COORD_W(W)) dut (
        .clk(clk), .n_rst(n_rst), .start(start),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .abort(abort), .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .x_o(x_o), .y_o(y_o), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Integer Bresenham walk producing the full expected pixel list.
    function automatic void model(input int ax, input int ay, input int bx, input int by);
        int dx, dy, sx, sy, err, e2, x, y;
        dx = iabs(bx - ax);
        dy = -iabs(by - ay);
        sx = (bx >= ax) ? 1 : -1;
        sy = (by >= ay) ? 1 : -1;
        err = dx + dy;
        x = ax;
        y = ay;
        exp_x.delete();
        exp_y.delete();
        for (int k = 0; k < 4096; k++) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
            if (x == bx && y == by) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endfunction

    always @(negedge clk) begin
        if (!n_rst) begin
            pv_prev = 0;
            pr_prev = 0;
        end else begin
            if (pix_valid) begin
                if (exp_x.size() == 0) begin
                    check("unexpected_pixel", pix_valid, 0);
                end else begin
                    if (pv_prev && !pr_prev && !ab_prev) begin
                        check("frozen_x", x_o, px_prev);
                        check("frozen_y", y_o, py_prev);
                    end
                    check("last_flag", last, (exp_x.size() == 1) ? 1 : 0);
                    if (pix_ready) begin
                        check("pix_x", x_o, exp_x[0]);
                        check("pix_y", y_o, exp_y[0]);
                        log_x.push_back(x_o);
                        log_y.push_back(y_o);
                        void'(exp_x.pop_front());
                        void'(exp_y.pop_front());
                    end
                end
            end
            pv_prev = pix_valid;
            pr_prev = pix_ready;
            ab_prev = abort;
            px_prev = x_o;
            py_prev = y_o;
        end
    end

    task automatic check_log(input string tag, input int i, input int ex, input int ey);
        if (i < log_x.size()) begin
            check({tag, "_x"}, log_x[i], ex);
            check({tag, "_y"}, log_y[i], ey);
        end else begin
            check({tag, "_missing"}, log_x.size(), i + 1);
        end
    endtask

    task automatic run_line(input int ax, input int ay, input int bx, input int by,
                            input bit bp, input bit noise);
        int n, emit, c_done;
        bit got_done;
        n = ((iabs(bx - ax) > iabs(by - ay)) ? iabs(bx - ax) : iabs(by - ay)) + 1;
        model(ax, ay, bx, by);
        log_x.delete();
        log_y.delete();
        x1 = ax[W-1:0]; y1 = ay[W-1:0]; x2 = bx[W-1:0]; y2 = by[W-1:0];
        start = 1'b1;
        pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        got_done = 0;
        emit = 0;
        c_done = -1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (noise && exp_x.size() > 3 && (c % 5) == 2) begin
                start = 1'b1;
                x1 = 8'd9; y1 = 8'd9; x2 = 8'd1; y2 = 8'd200;
            end
            pix_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (c == 0) begin
                check("first_valid", pix_valid, 1);
                check("first_busy", busy, 1);
            end
            if (pix_valid) emit++;
            if (done) begin
                got_done = 1;
                c_done = c;
                break;
            end
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        check("busy_at_done", busy, 0);
        check("valid_at_done", pix_valid, 0);
        check("pixels_left", exp_x.size(), 0);
        check("pixel_count", log_x.size(), n);
        if (!bp) begin
            check("emit_cycles", emit, n);
            check("done_latency", c_done, n);
        end
    endtask

    initial begin
        pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_last", last, 0);
        check("rst_done", done, 0);
        check("rst_x", x_o, 0);
        check("rst_y", y_o, 0);
        n_rst = 1'b1;
        @(negedge clk);

        run_line(0, 0, 3, 0, 0, 0);
        check_log("h0", 0, 0, 0);
        check_log("h3", 3, 3, 0);

        // Back-to-back: issued in the done cycle.
        run_line(0, 0, 1, 3, 0, 0);
        check_log("s1", 1, 0, 1);
        check_log("s2", 2, 1, 2);
        check_log("s3", 3, 1, 3);

        run_line(5, 5, 2, 2, 0, 0);
        check_log("r1", 1, 4, 4);
        check_log("r3", 3, 2, 2);

        run_line(0, 0, 3, 1, 1, 0);
        check_log("b1", 1, 1, 0);
        check_log("b2", 2, 2, 1);
        check_log("b3", 3, 3, 1);

        // Abort with the third pixel handshaked in the abort cycle.
        @(posedge clk); #1;
        model(0, 0, 10, 0);
        log_x.delete(); log_y.delete();
        x1 = 8'd0; y1 = 8'd0; x2 = 8'd10; y2 = 8'd0;
        pix_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", pix_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_consumed", log_x.size(), 3);
        check_log("a2", 2, 2, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        exp_x.delete(); exp_y.delete();

        run_line(7, 7, 7, 7, 0, 0);
        check_log("z0", 0, 7, 7);

        // Asynchronous reset mid-line.
        @(posedge clk); #1;
        model(0, 0, 10, 0);
        x1 = 8'd0; y1 = 8'd0; x2 = 8'd10; y2 = 8'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check("arst_valid", pix_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_x", x_o, 0);
        check("arst_last", last, 0);
        exp_x.delete(); exp_y.delete();
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst_no_done", done, 0);
            check("arst_idle", pix_valid, 0);
        end

        run_line(0, 0, 255, 0, 0, 1);
        check_log("e0", 0, 0, 0);
        check_log("e255", 255, 255, 0);
        run_line(255, 255, 0, 0, 0, 1);
        check_log("f0", 0, 255, 255);
        check_log("f128", 128, 127, 127);
        check_log("f255", 255, 0, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/line_stepper.md
# line_stepper

Parametrised sequential line rasteriser for the GPU draw path. It accepts two endpoints and emits every pixel of the line, one per cycle, using integer Bresenham stepping over any octant. A valid/ready handshake on the output lets the framebuffer writer stall it. It replaces the combinational group-size line estimator with a real pixel stream, adding abort, last-pixel marking and configurable coordinate width.

## Interface
- COORD_W, 16, width of each coordinate, unsigned; legal range 4..16
- clk  in  1  system clock, rising edge
- n_rst  in  1  reset, asynchronous and active-low
- start  in  1  command strobe; sampled only in IDLE
- x1, y1  in  COORD_W  start point, sampled with start
- x2, y2  in  COORD_W  end point, sampled with start
- abort  in  1  cancel the current line
- busy  out  1  high from the cycle after an accepted start until return to IDLE
- pix_valid  out  1  x_o/y_o hold a pixel
- pix_ready  in  1  consumer accepts the pixel when pix_valid is also high
- x_o, y_o  out  COORD_W  current pixel coordinate
- last  out  1  high with pix_valid on the endpoint pixel
- done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE, EMIT.
- IDLE with start=1: register the following values and go to EMIT.
  - x_o=x1, y_o=y1, xe=x2, ye=y2.
  - dx=|x2-x1| and dy=-|y2-y1|, both signed COORD_W+2.
  - sx=+1 if x2>=x1 else -1; sy likewise.
  - err=dx+dy, signed COORD_W+2.
- In IDLE, a start that arrives together with abort is still accepted; abort has no effect in IDLE.
- EMIT: pix_valid=1; last=(x_o==xe && y_o==ye), computed combinationally from the registers.
- On a handshake (pix_valid && pix_ready) in EMIT:
  - If last: go to IDLE and pulse done for one cycle.
  - Else: let e2=2*err, computed in COORD_W+3 bits signed.
    - If e2>=dy: x_o+=sx and add dy to the error.
    - If e2<=dx: y_o+=sy and add dx to the error.
    - Both conditions may apply in the same cycle; err gets the sum of both adds.
- No handshake: every register holds, so outputs are stable under backpressure.
- abort=1 in EMIT: go to IDLE next cycle; pix_valid drops; no done pulse. A pixel handshaked in the same cycle counts as consumed.
- start while busy is ignored.
- Zero-length line (x1==x2, y1==y2): exactly one pixel, with last=1.
- Coordinates never wrap, because stepping stops exactly at the endpoint. Intermediate error arithmetic must not overflow at dx=2^COORD_W-1.

## Timing
- Reset values: busy=0, pix_valid=0, last=0, done=0, x_o=0, y_o=0; state=IDLE; internal registers 0.
- The first pixel is valid on the cycle after the start edge (latency 1).
- With pix_ready held high, throughput is 1 pixel/cycle. A line of N pixels spends N cycles in EMIT, N = max(|dx|,|dy|)+1.
- done is asserted the cycle after the final handshake; busy falls in that same cycle.
- A new start is accepted in the cycle done is high (state is IDLE), so back-to-back lines have 1 idle cycle between them.
- n_rst asserted mid-line: all outputs go to their reset values immediately (asynchronous), and no done pulse is produced.

## Test plan
- (0,0)->(3,0), ready=1: pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles; last on the 4th; done 1 cycle later.
- Steep line (0,0)->(1,3): pixels (0,0),(0,1),(1,2),(1,3).
- Reverse diagonal (5,5)->(2,2): pixels (5,5),(4,4),(3,3),(2,2); the sx=sy=-1 path is exercised.
- Backpressure on (0,0)->(3,1): pix_ready toggled randomly. Outputs must stay frozen while ready=0, with no pixel lost or duplicated; sequence (0,0),(1,0),(2,1),(3,1).
- Abort and reset mid-line:
  - Abort after 2 accepted pixels of (0,0)->(10,0): pix_valid=0 next cycle, no done.
  - Then start (7,7)->(7,7): single pixel with last=1.
  - Drive n_rst low during EMIT: outputs clear immediately.
- Extremes with COORD_W=8: (0,0)->(255,0) gives 256 pixels, last only on (255,0). (255,255)->(0,0) gives 256 pixels. No overflow or wrap; start pulses while busy are ignored.
